// File: rtl/sum_group_accumulator.sv
// Sums consecutive groups of group_size stream items into widened totals;
// flush closes a partial group early. Single-entry registered output stage.
module sum_group_accumulator #(
   parameter  int width      = 4,
   parameter  int group_size = 4,
   localparam int acc_width  = width + $clog2(group_size),
   localparam int cnt_width  = $clog2(group_size + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [width-1:0]     in_data,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [acc_width-1:0] out_data,
   output logic [cnt_width-1:0] out_count
);

   localparam logic [cnt_width-1:0] CNT_LAST = cnt_width'(group_size - 1);
   localparam logic [cnt_width-1:0] CNT_ONE  = cnt_width'(1);

   logic [acc_width-1:0] acc_q, acc_d;
   logic [cnt_width-1:0] cnt_q, cnt_d;
   logic                 out_valid_q, out_valid_d;
   logic [acc_width-1:0] out_data_q, out_data_d;
   logic [cnt_width-1:0] out_count_q, out_count_d;

   logic                 accept;
   logic                 flush_eff;
   logic                 last_item;
   logic [acc_width-1:0] item_ext;
   logic [acc_width-1:0] sum;

   // The output register can take a new total whenever it is empty or draining.
   assign in_ready  = ~out_valid_q | out_ready;
   assign accept    = in_valid & in_ready;
   assign flush_eff = flush & in_ready;
   assign last_item = (cnt_q == CNT_LAST);
   assign item_ext  = {{(acc_width - width){1'b0}}, in_data};
   assign sum       = acc_q + item_ext;

   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (accept && (last_item || flush_eff)) begin
         // Accepted item closes the group (full, or flushed with it included).
         out_data_d  = sum;
         out_count_d = cnt_q + CNT_ONE;
         out_valid_d = 1'b1;
         acc_d       = '0;
         cnt_d       = '0;
      end else if (accept) begin
         acc_d = sum;
         cnt_d = cnt_q + CNT_ONE;
      end else if (flush_eff && (cnt_q != '0)) begin
         out_data_d  = acc_q;
         out_count_d = cnt_q;
         out_valid_d = 1'b1;
         acc_d       = '0;
         cnt_d       = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_count_q <= '0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_count = out_count_q;

endmodule

// File: tb/tb_sum_group_accumulator.sv
// Scoreboard bench for sum_group_accumulator: a queue-based group model predicts
// totals, counts and output-valid timing; a negedge monitor compares.
module tb_sum_group_accumulator;

   localparam int W  = 4;
   localparam int G  = 4;
   localparam int AW = W + $clog2(G);
   localparam int CW = $clog2(G + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_data;
   logic [CW-1:0] out_count;

   int n_checks = 0;
   int n_fail   = 0;

   int grp[$];
   int exp_data[$];
   int exp_cnt[$];
   bit started    = 1'b0;
   bit pred_valid = 1'b0;
   bit stall_prev = 1'b0;
   int prev_data;
   int prev_cnt;
   bit rand_phase = 1'b0;

   sum_group_accumulator #(.width(W), .group_size(G)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_count(out_count)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, int act, int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endfunction

   function automatic int group_total();
      int s = 0;
      foreach (grp[i]) s += grp[i];
      return s;
   endfunction

   // Monitor: signals are stable at negedge and describe the upcoming posedge.
   always @(negedge clk) begin
      if (started) begin
         bit acc;
         bit close;
         chk("out_valid_timing", int'(out_valid), int'(pred_valid));
         if (stall_prev && out_valid) begin
            chk("held_data", int'(out_data), prev_data);
            chk("held_count", int'(out_count), prev_cnt);
         end
         chk("in_ready_rule", int'(in_ready), int'((!out_valid) || out_ready));
         if (out_valid && out_ready) begin
            if (exp_data.size() == 0) begin
               chk("unexpected_output", int'(out_data), -1);
            end else begin
               chk("out_data", int'(out_data), exp_data.pop_front());
               chk("out_count", int'(out_count), exp_cnt.pop_front());
            end
         end
         close = 1'b0;
         if (rst) begin
            grp.delete();
            exp_data.delete();
            exp_cnt.delete();
            pred_valid = 1'b0;
            stall_prev = 1'b0;
         end else begin
            acc = in_valid && in_ready;
            if (acc) grp.push_back(int'(in_data));
            if (grp.size() == G) close = 1'b1;
            else if (flush && in_ready && grp.size() > 0) close = 1'b1;
            if (close) begin
               exp_data.push_back(group_total());
               exp_cnt.push_back(grp.size());
               grp.delete();
            end
            pred_valid = close || (out_valid && !out_ready);
            stall_prev = out_valid && !out_ready;
            prev_data  = int'(out_data);
            prev_cnt   = int'(out_count);
         end
      end
   end

   task automatic wait_ready(string what);
      bit r;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         r = in_ready;
         @(posedge clk);
         #1;
         if (r) return;
      end
      chk({what, "_timeout"}, 0, 1);
   endtask

   task automatic send(int d, bit fl);
      in_valid = 1'b1;
      in_data  = W'(d);
      flush    = fl;
      wait_ready("send");
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic do_flush();
      in_valid = 1'b0;
      flush    = 1'b1;
      wait_ready("flush");
      flush = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_out_data", int'(out_data), 0);
      chk("reset_out_count", int'(out_count), 0);
      started = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;

      // Back-to-back sequence 1..8, then saturating values
      for (int i = 1; i <= 8; i++) send(i, 1'b0);
      for (int i = 0; i < 4; i++) send(15, 1'b0);
      idle(2);

      // Backpressure: total held, then simultaneous drain and accept
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(1, 1'b0);
      in_valid = 1'b1; in_data = 4'd2;
      idle(5);
      out_ready = 1'b1;
      send(2, 1'b0);
      for (int i = 0; i < 3; i++) send(2, 1'b0);
      idle(2);

      // Flush of a partial group, then flush of an empty group
      for (int i = 0; i < 3; i++) send(2, 1'b0);
      do_flush();
      idle(2);
      do_flush();
      idle(3);

      // Flush coincident with accepts
      send(3, 1'b0);
      send(5, 1'b1);
      for (int i = 0; i < 3; i++) send(1, 1'b0);
      send(1, 1'b1);
      idle(2);

      // Reset mid-group discards the partial sum
      send(7, 1'b0);
      send(7, 1'b0);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) send(1, 1'b0);
      idle(2);

      // Random transfers with random downstream readiness
      rand_phase = 1'b1;
      fork
         begin
            for (int n = 0; n < 100; n++) begin
               if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
               send($urandom_range(0, 15), ($urandom_range(0, 7) == 0));
            end
            rand_phase = 1'b0;
         end
         begin
            while (rand_phase) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 2) != 0);
            end
         end
      join
      out_ready = 1'b1;
      do_flush();
      idle(6);
      chk("scoreboard_drained", exp_data.size(), 0);
      chk("group_drained", grp.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
